// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-step controller: FSM state codes,
// direction codes, playfield geometry and a small direction helper.
package snake_pkg;

  localparam int CW   = 5;
  localparam int GRID = 24;

  localparam logic [CW-1:0] WALL_LO = 5'd1;
  localparam logic [CW-1:0] WALL_HI = 5'd22;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    ST_MENU = 3'd0,
    ST_INIT = 3'd1,
    ST_WAIT = 3'd2,
    ST_CALC = 3'd3,
    ST_SCAN = 3'd4,
    ST_MOVE = 3'd5,
    ST_GROW = 3'd6,
    ST_OVER = 3'd7
  } state_t;

  // Opposite directions share the axis bit and differ only in the sign bit.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return ((a ^ b) == 2'b01);
  endfunction

endpackage

// File: rtl/snake_body_ring.sv
// Ring-buffer register file holding the snake body. Segment i (0 = head)
// lives at (head_ptr - i) mod MAX_LEN, so pushing a new head never moves data.
module snake_body_ring
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int IDXW     = 4,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 12,
  parameter int START_Y  = 11
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             init,
  input  logic             push,
  input  logic [2*CW-1:0]  push_seg,
  input  logic [IDXW-1:0]  scan_idx,
  output logic [2*CW-1:0]  scan_seg,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [2*CW-1:0]  rd_seg
);

  logic [2*CW-1:0] mem_r [MAX_LEN];
  logic [IDXW-1:0] head_ptr_r;

  // Storage and head pointer: load the starting body, or push one new head.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head_ptr_r <= {IDXW{1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_r[i] <= {(2*CW){1'b0}};
      end
    end else if (init) begin
      // Head at slot 0, body trailing leftwards into the slots behind it.
      head_ptr_r <= {IDXW{1'b0}};
      for (int i = 0; i < INIT_LEN; i++) begin
        mem_r[IDXW'(MAX_LEN - i)] <= {CW'(START_X - i), CW'(START_Y)};
      end
    end else if (push) begin
      head_ptr_r                  <= head_ptr_r + IDXW'(1);
      mem_r[head_ptr_r + IDXW'(1)] <= push_seg;
    end else begin
      head_ptr_r <= head_ptr_r;
    end
  end

  // Index-relative reads; the modulo falls out of the IDXW-bit subtraction.
  assign scan_seg = mem_r[head_ptr_r - scan_idx];
  assign rd_seg   = mem_r[head_ptr_r - rd_idx];

endmodule

// File: rtl/snake_step_sequencer.sv
// Game-step controller: on each tick, compute the next head cell, check the
// walls and the body one segment per cycle, then move, grow or end the game.
module snake_step_sequencer
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 12,
  parameter int START_Y  = 11,
  localparam int IDXW    = $clog2(MAX_LEN)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            start,
  input  logic            tick,
  input  logic [1:0]      dir,
  input  logic [4:0]      apple_x,
  input  logic [4:0]      apple_y,
  output logic            apple_req,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_valid,
  output logic [4:0]      rd_x,
  output logic [4:0]      rd_y,
  output logic [4:0]      head_x,
  output logic [4:0]      head_y,
  output logic [IDXW:0]   len,
  output logic [2:0]      state,
  output logic            game_over
);

  localparam logic [IDXW:0] LEN_ZERO = {(IDXW+1){1'b0}};
  localparam logic [IDXW:0] LEN_ONE  = (IDXW+1)'(1);
  localparam logic [IDXW:0] LEN_INIT = (IDXW+1)'(INIT_LEN);
  localparam logic [IDXW:0] LEN_MAX  = (IDXW+1)'(MAX_LEN);

  state_t          state_r, next_state_s;
  logic            start_q_r;
  logic [IDXW:0]   len_r;
  logic [CW-1:0]   head_x_r, head_y_r;
  logic [1:0]      heading_r;
  logic [CW-1:0]   nx_r, ny_r;
  logic            hit_apple_r;
  logic [IDXW-1:0] scan_idx_r;
  logic            apple_req_r, game_over_r, rd_valid_r;
  logic [CW-1:0]   rd_x_r, rd_y_r;

  logic            start_rise_s;
  logic [CW-1:0]   nx_s, ny_s;
  logic            wall_s;
  logic [IDXW:0]   lim_s;
  logic            scan_last_s;
  logic            seg_match_s;
  logic [2*CW-1:0] scan_seg_s, rd_seg_s;
  logic            ring_init_s, ring_push_s;

  assign start_rise_s = start & ~start_q_r;
  // When an apple is eaten the tail stays, so it must be scanned too.
  assign lim_s        = hit_apple_r ? len_r : (len_r - LEN_ONE);
  assign scan_last_s  = ({1'b0, scan_idx_r} == (lim_s - LEN_ONE));
  assign seg_match_s  = (scan_seg_s == {nx_r, ny_r});
  assign wall_s       = (nx_s <= WALL_LO) || (nx_s >= WALL_HI) ||
                        (ny_s <= WALL_LO) || (ny_s >= WALL_HI);
  assign ring_init_s  = (state_r == ST_INIT);
  assign ring_push_s  = (state_r == ST_MOVE) || (state_r == ST_GROW);

  snake_body_ring #(
    .MAX_LEN  (MAX_LEN),
    .IDXW     (IDXW),
    .INIT_LEN (INIT_LEN),
    .START_X  (START_X),
    .START_Y  (START_Y)
  ) u_ring (
    .clk      (clk),
    .clrn     (clrn),
    .init     (ring_init_s),
    .push     (ring_push_s),
    .push_seg ({nx_r, ny_r}),
    .scan_idx (scan_idx_r),
    .scan_seg (scan_seg_s),
    .rd_idx   (rd_idx),
    .rd_seg   (rd_seg_s)
  );

  // Candidate next head: one step from the current head along the heading.
  always_comb begin
    nx_s = head_x_r;
    ny_s = head_y_r;
    case (heading_r)
      DIR_UP:    ny_s = head_y_r - 5'd1;
      DIR_DOWN:  ny_s = head_y_r + 5'd1;
      DIR_LEFT:  nx_s = head_x_r - 5'd1;
      DIR_RIGHT: nx_s = head_x_r + 5'd1;
      default: begin
        nx_s = head_x_r;
        ny_s = head_y_r;
      end
    endcase
  end

  // Next-state logic of the step FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_MENU: begin
        if (start_rise_s) next_state_s = ST_INIT;
        else              next_state_s = ST_MENU;
      end
      ST_INIT: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (tick) next_state_s = ST_CALC;
        else      next_state_s = ST_WAIT;
      end
      ST_CALC: begin
        if (wall_s) next_state_s = ST_OVER;
        else        next_state_s = ST_SCAN;
      end
      ST_SCAN: begin
        if (lim_s == LEN_ZERO)  next_state_s = hit_apple_r ? ST_GROW : ST_MOVE;
        else if (seg_match_s)   next_state_s = ST_OVER;
        else if (scan_last_s)   next_state_s = hit_apple_r ? ST_GROW : ST_MOVE;
        else                    next_state_s = ST_SCAN;
      end
      ST_MOVE: next_state_s = ST_WAIT;
      ST_GROW: next_state_s = ST_WAIT;
      ST_OVER: begin
        if (start_rise_s) next_state_s = ST_MENU;
        else              next_state_s = ST_OVER;
      end
      default: next_state_s = ST_MENU;
    endcase
  end

  // State register plus the per-state datapath updates.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r     <= ST_MENU;
      start_q_r   <= 1'b0;
      len_r       <= LEN_ZERO;
      head_x_r    <= 5'd0;
      head_y_r    <= 5'd0;
      heading_r   <= DIR_RIGHT;
      nx_r        <= 5'd0;
      ny_r        <= 5'd0;
      hit_apple_r <= 1'b0;
      scan_idx_r  <= {IDXW{1'b0}};
    end else begin
      state_r   <= next_state_s;
      start_q_r <= start;
      case (state_r)
        ST_INIT: begin
          len_r     <= LEN_INIT;
          head_x_r  <= CW'(START_X);
          head_y_r  <= CW'(START_Y);
          heading_r <= DIR_RIGHT;
        end
        ST_WAIT: begin
          if (tick && !is_reverse(dir, heading_r)) heading_r <= dir;
        end
        ST_CALC: begin
          nx_r        <= nx_s;
          ny_r        <= ny_s;
          hit_apple_r <= (nx_s == apple_x) && (ny_s == apple_y);
          scan_idx_r  <= {IDXW{1'b0}};
        end
        ST_SCAN: scan_idx_r <= scan_idx_r + IDXW'(1);
        ST_MOVE: begin
          head_x_r <= nx_r;
          head_y_r <= ny_r;
        end
        ST_GROW: begin
          head_x_r <= nx_r;
          head_y_r <= ny_r;
          if (len_r < LEN_MAX) len_r <= len_r + LEN_ONE;
        end
        ST_OVER: begin
          if (start_rise_s) len_r <= LEN_ZERO;
        end
        default: begin
          len_r <= len_r;
        end
      endcase
    end
  end

  // Registered status outputs, timed to coincide with the state they report.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      apple_req_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      apple_req_r <= (next_state_s == ST_GROW);
      game_over_r <= (next_state_s == ST_OVER);
    end
  end

  // Renderer read port: one-cycle latency, zeros beyond the body.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_valid_r <= 1'b0;
      rd_x_r     <= 5'd0;
      rd_y_r     <= 5'd0;
    end else if ({1'b0, rd_idx} < len_r) begin
      rd_valid_r <= 1'b1;
      rd_x_r     <= rd_seg_s[2*CW-1:CW];
      rd_y_r     <= rd_seg_s[CW-1:0];
    end else begin
      rd_valid_r <= 1'b0;
      rd_x_r     <= 5'd0;
      rd_y_r     <= 5'd0;
    end
  end

  assign apple_req = apple_req_r;
  assign game_over = game_over_r;
  assign rd_valid  = rd_valid_r;
  assign rd_x      = rd_x_r;
  assign rd_y      = rd_y_r;
  assign head_x    = head_x_r;
  assign head_y    = head_y_r;
  assign len       = len_r;
  assign state     = state_r;

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Directed testbench for snake_step_sequencer (default parameters).
module tb_snake_step_sequencer;

  logic       clk, clrn, start, tick;
  logic [1:0] dir;
  logic [4:0] apple_x, apple_y;
  logic       apple_req;
  logic [3:0] rd_idx;
  logic       rd_valid;
  logic [4:0] rd_x, rd_y, head_x, head_y;
  logic [4:0] len;
  logic [2:0] state;
  logic       game_over;

  int checks = 0;
  int errors = 0;
  int areq_cnt = 0;
  int areq_bad = 0;

  snake_step_sequencer dut (
    .clk(clk), .clrn(clrn), .start(start), .tick(tick), .dir(dir),
    .apple_x(apple_x), .apple_y(apple_y), .apple_req(apple_req),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y),
    .head_x(head_x), .head_y(head_y), .len(len), .state(state),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count apple_req cycles, and any that fall outside GROW.
  always @(negedge clk) begin
    if (clrn && apple_req) begin
      areq_cnt++;
      if (state != 3'd6) areq_bad++;
    end
  end

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // One game step: tick in WAIT, then wait (bounded) for WAIT or OVER.
  task automatic do_step(input logic [1:0] d);
    int n;
    dir  = d;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n = 0;
    while (state != 3'd2 && state != 3'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL step_timeout: state %0d after %0d cycles, expected WAIT or OVER", state, n);
    end
  endtask

  task automatic read_seg(input logic [3:0] idx, output logic [4:0] x,
                          output logic [4:0] y, output logic v);
    rd_idx = idx;
    @(negedge clk);
    x = rd_x; y = rd_y; v = rd_valid;
  endtask

  task automatic test_reset();
    clrn = 1'b0; start = 1'b0; tick = 1'b0; dir = 2'b11;
    apple_x = 5'd3; apple_y = 5'd3; rd_idx = 4'd0;
    @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (len !== 5'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", len); end
    checks++; if ({head_x, head_y} !== 10'd0) begin errors++; $display("FAIL reset_head got (%0d,%0d) exp (0,0)", head_x, head_y); end
    checks++; if ({apple_req, game_over, rd_valid, rd_x, rd_y} !== 13'd0) begin errors++; $display("FAIL reset_outs got req=%b go=%b v=%b rd=(%0d,%0d) exp all 0", apple_req, game_over, rd_valid, rd_x, rd_y); end
    clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start();
    logic [4:0] x, y; logic v;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL menu_tick_dropped got %0d exp 0", state); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_init got %0d exp 1", state); end
    @(negedge clk);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL start_wait got %0d exp 2", state); end
    checks++; if (len !== 5'd3) begin errors++; $display("FAIL start_len got %0d exp 3", len); end
    checks++; if (head_x !== 5'd12 || head_y !== 5'd11) begin errors++; $display("FAIL start_head got (%0d,%0d) exp (12,11)", head_x, head_y); end
    read_seg(4'd0, x, y, v);
    checks++; if (x !== 5'd12 || y !== 5'd11 || v !== 1'b1) begin errors++; $display("FAIL seg0 got (%0d,%0d,%b) exp (12,11,1)", x, y, v); end
    read_seg(4'd1, x, y, v);
    checks++; if (x !== 5'd11 || y !== 5'd11 || v !== 1'b1) begin errors++; $display("FAIL seg1 got (%0d,%0d,%b) exp (11,11,1)", x, y, v); end
    read_seg(4'd2, x, y, v);
    checks++; if (x !== 5'd10 || y !== 5'd11 || v !== 1'b1) begin errors++; $display("FAIL seg2 got (%0d,%0d,%b) exp (10,11,1)", x, y, v); end
    read_seg(4'd3, x, y, v);
    checks++; if (x !== 5'd0 || y !== 5'd0 || v !== 1'b0) begin errors++; $display("FAIL seg3_invalid got (%0d,%0d,%b) exp (0,0,0)", x, y, v); end
    press_start();
    checks++; if (state !== 3'd2 || len !== 5'd3) begin errors++; $display("FAIL wait_start_ignored got state %0d len %0d exp 2/3", state, len); end
  endtask

  task automatic test_move();
    logic [4:0] x, y; logic v; int base;
    base = areq_cnt;
    for (int i = 0; i < 4; i++) do_step(2'b11);
    checks++; if (head_x !== 5'd16 || head_y !== 5'd11) begin errors++; $display("FAIL move_head got (%0d,%0d) exp (16,11)", head_x, head_y); end
    checks++; if (len !== 5'd3) begin errors++; $display("FAIL move_len got %0d exp 3", len); end
    checks++; if (areq_cnt - base !== 0) begin errors++; $display("FAIL move_no_apple_req got %0d pulses exp 0", areq_cnt - base); end
    read_seg(4'd2, x, y, v);
    checks++; if (x !== 5'd14 || y !== 5'd11) begin errors++; $display("FAIL move_seg2 got (%0d,%0d) exp (14,11)", x, y); end
  endtask

  task automatic test_grow();
    logic [4:0] x, y; logic v; int base;
    base = areq_cnt;
    apple_x = 5'd17; apple_y = 5'd11;
    do_step(2'b11);
    apple_x = 5'd3; apple_y = 5'd3;
    checks++; if (areq_cnt - base !== 1) begin errors++; $display("FAIL grow_apple_req got %0d pulses exp 1", areq_cnt - base); end
    checks++; if (len !== 5'd4) begin errors++; $display("FAIL grow_len got %0d exp 4", len); end
    checks++; if (head_x !== 5'd17 || head_y !== 5'd11) begin errors++; $display("FAIL grow_head got (%0d,%0d) exp (17,11)", head_x, head_y); end
    read_seg(4'd3, x, y, v);
    checks++; if (x !== 5'd14 || y !== 5'd11 || v !== 1'b1) begin errors++; $display("FAIL grow_tail got (%0d,%0d,%b) exp (14,11,1)", x, y, v); end
  endtask

  task automatic test_reverse();
    do_step(2'b10);
    checks++; if (head_x !== 5'd18 || head_y !== 5'd11) begin errors++; $display("FAIL reverse_ignored got (%0d,%0d) exp (18,11)", head_x, head_y); end
    do_step(2'b00);
    checks++; if (head_x !== 5'd18 || head_y !== 5'd10) begin errors++; $display("FAIL turn_up got (%0d,%0d) exp (18,10)", head_x, head_y); end
  endtask

  task automatic test_wall();
    logic [4:0] x, y; logic v;
    for (int i = 0; i < 3; i++) do_step(2'b11);
    checks++; if (state !== 3'd2 || head_x !== 5'd21) begin errors++; $display("FAIL wall_x21 got state %0d x %0d exp 2/21", state, head_x); end
    do_step(2'b11);
    checks++; if (state !== 3'd7 || game_over !== 1'b1) begin errors++; $display("FAIL wall_over got state %0d go %b exp 7/1", state, game_over); end
    checks++; if (head_x !== 5'd21 || head_y !== 5'd10 || len !== 5'd4) begin errors++; $display("FAIL wall_frozen got (%0d,%0d) len %0d exp (21,10) 4", head_x, head_y, len); end
    read_seg(4'd0, x, y, v);
    checks++; if (x !== 5'd21 || y !== 5'd10 || v !== 1'b1) begin errors++; $display("FAIL over_readable got (%0d,%0d,%b) exp (21,10,1)", x, y, v); end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd7 || head_x !== 5'd21) begin errors++; $display("FAIL over_tick_dropped got state %0d x %0d exp 7/21", state, head_x); end
    press_start();
    checks++; if (state !== 3'd0 || len !== 5'd0 || game_over !== 1'b0) begin errors++; $display("FAIL over_to_menu got state %0d len %0d go %b exp 0/0/0", state, len, game_over); end
  endtask

  task automatic test_self_hit();
    press_start();
    checks++; if (state !== 3'd2 || len !== 5'd3) begin errors++; $display("FAIL restart got state %0d len %0d exp 2/3", state, len); end
    apple_x = 5'd13; apple_y = 5'd11;
    do_step(2'b11);
    apple_x = 5'd14;
    do_step(2'b11);
    apple_x = 5'd3; apple_y = 5'd3;
    checks++; if (len !== 5'd5 || head_x !== 5'd14) begin errors++; $display("FAIL len5_setup got len %0d x %0d exp 5/14", len, head_x); end
    do_step(2'b00);
    do_step(2'b10);
    do_step(2'b01);
    checks++; if (state !== 3'd7 || game_over !== 1'b1) begin errors++; $display("FAIL self_hit_over got state %0d go %b exp 7/1", state, game_over); end
    checks++; if (head_x !== 5'd13 || head_y !== 5'd10 || len !== 5'd5) begin errors++; $display("FAIL self_hit_head got (%0d,%0d) len %0d exp (13,10) 5", head_x, head_y, len); end
  endtask

  task automatic test_tail_chase();
    press_start();
    press_start();
    apple_x = 5'd13; apple_y = 5'd11;
    do_step(2'b11);
    apple_x = 5'd3; apple_y = 5'd3;
    checks++; if (len !== 5'd4 || head_x !== 5'd13 || head_y !== 5'd11) begin errors++; $display("FAIL len4_setup got len %0d (%0d,%0d) exp 4 (13,11)", len, head_x, head_y); end
    do_step(2'b00);
    do_step(2'b10);
    do_step(2'b01);
    checks++; if (state !== 3'd2 || head_x !== 5'd12 || head_y !== 5'd11) begin errors++; $display("FAIL tail_chase1 got state %0d (%0d,%0d) exp 2 (12,11)", state, head_x, head_y); end
    do_step(2'b11);
    checks++; if (state !== 3'd2 || head_x !== 5'd13 || head_y !== 5'd11 || len !== 5'd4) begin errors++; $display("FAIL tail_chase2 got state %0d (%0d,%0d) len %0d exp 2 (13,11) 4", state, head_x, head_y, len); end
  endtask

  task automatic test_reset_mid_scan();
    rd_idx = 4'd0;
    dir  = 2'b11;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL reach_scan got %0d exp 4", state); end
    clrn = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || len !== 5'd0 || head_x !== 5'd0 || head_y !== 5'd0) begin errors++; $display("FAIL midscan_reset got state %0d len %0d (%0d,%0d) exp 0 0 (0,0)", state, len, head_x, head_y); end
    checks++; if ({apple_req, game_over, rd_valid, rd_x, rd_y} !== 13'd0) begin errors++; $display("FAIL midscan_reset_outs got req=%b go=%b v=%b rd=(%0d,%0d) exp all 0", apple_req, game_over, rd_valid, rd_x, rd_y); end
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL after_reset_state got %0d exp 0", state); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_move();
    test_grow();
    test_reverse();
    test_wall();
    test_self_hit();
    test_tail_chase();
    test_reset_mid_scan();
    checks++; if (areq_bad !== 0) begin errors++; $display("FAIL apple_req_outside_grow got %0d cycles exp 0", areq_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
